// File: rtl/fifo_sample_packer_if.sv
// Bundle between the CIC filter/FIFO side and fifo_sample_packer.
// Signals: standby, sample strobe/data, fifo_entries in; FIFO write, xyz, ovr, busy out.
interface fifo_sample_packer_if #(
   parameter int IN_WIDTH = 35
);
   logic                       standby;
   logic                       sample_vld;
   logic signed [IN_WIDTH-1:0] x_in;
   logic signed [IN_WIDTH-1:0] y_in;
   logic signed [IN_WIDTH-1:0] z_in;
   logic [6:0]                 fifo_entries;
   logic                       wr_en;
   logic [23:0]                filter_fifo_data;
   logic [19:0]                xdata;
   logic [19:0]                ydata;
   logic [19:0]                zdata;
   logic                       xdata_valid;
   logic                       ydata_valid;
   logic                       zdata_valid;
   logic                       fifo_ovr;
   logic                       busy;

   modport master (
      output standby, sample_vld, x_in, y_in, z_in, fifo_entries,
      input  wr_en, filter_fifo_data, xdata, ydata, zdata,
      input  xdata_valid, ydata_valid, zdata_valid, fifo_ovr, busy
   );

   modport slave (
      input  standby, sample_vld, x_in, y_in, z_in, fifo_entries,
      output wr_en, filter_fifo_data, xdata, ydata, zdata,
      output xdata_valid, ydata_valid, zdata_valid, fifo_ovr, busy
   );
endinterface

// File: rtl/fifo_sample_packer.sv
// Packs one scaled X/Y/Z sample set into three 24-bit FIFO words and mirrors it.
// Ports: mems_clk, rst_n (sync, active low), bus (slave side of fifo_sample_packer_if).
// Option: define FIFO_PACK_SAT_EN to saturate instead of truncate to 20 bits.
module fifo_sample_packer #(
   parameter int IN_WIDTH = 35,
   parameter int SHIFT    = 14,
   parameter int DEPTH    = 16
) (
   input logic                  mems_clk,
   input logic                  rst_n,
   fifo_sample_packer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WX, WY, WZ} state_t;

   state_t      state;
   state_t      state_nx;
   logic        wr_q;
   logic        wr_nx;
   logic [23:0] data_q;
   logic [23:0] data_nx;
   logic        ovr_q;
   logic        ovr_nx;
   logic        vld_q;
   logic        load;
   logic        take;
   logic        room;
   logic [19:0] xs;
   logic [19:0] ys;
   logic [19:0] zs;
   logic [19:0] x_q;
   logic [19:0] y_q;
   logic [19:0] z_q;

`ifdef FIFO_PACK_SAT_EN
   localparam logic signed [IN_WIDTH-1:0] SMAX = 524287;
   localparam logic signed [IN_WIDTH-1:0] SMIN = -524288;

   function automatic logic [19:0] scale(input logic signed [IN_WIDTH-1:0] v);
      logic signed [IN_WIDTH-1:0] s;
      s = v >>> SHIFT;
      if (s > SMAX)      scale = 20'h7FFFF;
      else if (s < SMIN) scale = 20'h80000;
      else               scale = 20'(s);
   endfunction
`else
   function automatic logic [19:0] scale(input logic signed [IN_WIDTH-1:0] v);
      scale = 20'(v >>> SHIFT);
   endfunction
`endif

   assign xs = scale(bus.x_in);
   assign ys = scale(bus.y_in);
   assign zs = scale(bus.z_in);

   assign take = bus.sample_vld && !bus.standby;
   // A set is only started when all three words fit, keeping sets atomic.
   assign room = ({1'b0, bus.fifo_entries} + 8'd3) <= 8'(DEPTH);

   always_comb begin
      state_nx = state;
      wr_nx    = 1'b0;
      data_nx  = data_q;
      ovr_nx   = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (take) begin
               load = 1'b1;
               if (room) begin
                  state_nx = WX;
                  wr_nx    = 1'b1;
                  data_nx  = {xs, 4'b0001};
               end else begin
                  ovr_nx = 1'b1;
               end
            end
         end
         WX: begin
            state_nx = WY;
            wr_nx    = 1'b1;
            data_nx  = {y_q, 4'b0000};
            ovr_nx   = take;
         end
         WY: begin
            state_nx = WZ;
            wr_nx    = 1'b1;
            data_nx  = {z_q, 4'b0000};
            ovr_nx   = take;
         end
         WZ: begin
            state_nx = IDLE;
            ovr_nx   = take;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge mems_clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         wr_q   <= 1'b0;
         data_q <= '0;
         ovr_q  <= 1'b0;
         vld_q  <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
      end else begin
         state  <= state_nx;
         wr_q   <= wr_nx;
         data_q <= data_nx;
         ovr_q  <= ovr_nx;
         vld_q  <= load;
         if (load) begin
            x_q <= xs;
            y_q <= ys;
            z_q <= zs;
         end
      end
   end

   assign bus.wr_en            = wr_q;
   assign bus.filter_fifo_data = data_q;
   assign bus.xdata            = x_q;
   assign bus.ydata            = y_q;
   assign bus.zdata            = z_q;
   assign bus.xdata_valid      = vld_q;
   assign bus.ydata_valid      = vld_q;
   assign bus.zdata_valid      = vld_q;
   assign bus.fifo_ovr         = ovr_q;
   assign bus.busy             = (state != IDLE);

endmodule

// File: tb/tb_fifo_sample_packer.sv
// Randomized bench for fifo_sample_packer against a word-queue reference model.
// Drives the master side of fifo_sample_packer_if; checks every cycle.
module tb_fifo_sample_packer;

   logic clk;
   logic rst_n;

   fifo_sample_packer_if #(.IN_WIDTH(35)) bus ();

   fifo_sample_packer #(
      .IN_WIDTH(35),
      .SHIFT(14),
      .DEPTH(16)
   ) dut (
      .mems_clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   logic [23:0] word_q[$];
   logic        prev_wrote;
   logic        e_wr;
   logic [23:0] e_data;
   logic [19:0] e_x;
   logic [19:0] e_y;
   logic [19:0] e_z;
   logic        e_vld;
   logic        e_ovr;
   logic        e_busy;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] ref_scale(input longint v);
      longint q;
      q = v / 16384;
      if (v < 0 && q * 16384 != v) q = q - 1;
`ifdef FIFO_PACK_SAT_EN
      if (q > 524287)  q = 524287;
      if (q < -524288) q = -524288;
`endif
      return 20'(q);
   endfunction

   task automatic model(input logic r, input logic sb, input logic stb,
                        input longint x, input longint y, input longint z,
                        input int fe);
      if (!r) begin
         word_q.delete();
         prev_wrote = 1'b0;
         e_wr = 1'b0;
         e_data = '0;
         e_x = '0;
         e_y = '0;
         e_z = '0;
         e_vld = 1'b0;
         e_ovr = 1'b0;
         e_busy = 1'b0;
      end else begin
         e_vld = 1'b0;
         e_ovr = 1'b0;
         if (stb && !sb) begin
            if (!prev_wrote) begin
               e_x = ref_scale(x);
               e_y = ref_scale(y);
               e_z = ref_scale(z);
               e_vld = 1'b1;
               if (16 - fe >= 3) begin
                  word_q.push_back({e_x, 4'b0001});
                  word_q.push_back({e_y, 4'b0000});
                  word_q.push_back({e_z, 4'b0000});
               end else begin
                  e_ovr = 1'b1;
               end
            end else begin
               e_ovr = 1'b1;
            end
         end
         if (word_q.size() > 0) begin
            e_data = word_q.pop_front();
            e_wr = 1'b1;
         end else begin
            e_wr = 1'b0;
         end
         e_busy = e_wr;
         prev_wrote = e_wr;
      end
   endtask

   task automatic step(input logic r, input logic sb, input logic stb,
                       input longint x, input longint y, input longint z,
                       input int fe);
      rst_n = r;
      bus.standby = sb;
      bus.sample_vld = stb;
      bus.x_in = 35'(x);
      bus.y_in = 35'(y);
      bus.z_in = 35'(z);
      bus.fifo_entries = 7'(fe);
      @(posedge clk);
      #1;
      model(r, sb, stb, x, y, z, fe);
      check("wr_en", 64'(bus.wr_en), 64'(e_wr));
      check("data", 64'(bus.filter_fifo_data), 64'(e_data));
      check("xdata", 64'(bus.xdata), 64'(e_x));
      check("ydata", 64'(bus.ydata), 64'(e_y));
      check("zdata", 64'(bus.zdata), 64'(e_z));
      check("xvld", 64'(bus.xdata_valid), 64'(e_vld));
      check("yvld", 64'(bus.ydata_valid), 64'(e_vld));
      check("zvld", 64'(bus.zdata_valid), 64'(e_vld));
      check("ovr", 64'(bus.fifo_ovr), 64'(e_ovr));
      check("busy", 64'(bus.busy), 64'(e_busy));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic longint rnd_val();
      longint r;
      r = longint'({$urandom(), $urandom()});
      if ($urandom_range(0, 1) == 0)
         return (r & ((longint'(1) << 35) - 1)) - (longint'(1) << 34);
      return (r & ((longint'(1) << 25) - 1)) - (longint'(1) << 24);
   endfunction

   logic [23:0] sat_z;

   initial begin
      checks = 0;
      failures = 0;
      prev_wrote = 1'b0;
`ifdef FIFO_PACK_SAT_EN
      sat_z = 24'h7FFFF0;
`else
      sat_z = 24'hFFFFF0;
`endif
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 81920, 0, 0, 0);
      check("rst_wr", 64'(bus.wr_en), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_data", 64'(bus.filter_fifo_data), 64'd0);

      // basic set
      step(1, 0, 1, 81920, -16384, 0, 0);
      check("t1_xw", 64'(bus.filter_fifo_data), 64'h000051);
      check("t1_xdata", 64'(bus.xdata), 64'd5);
      check("t1_ydata", 64'(bus.ydata), 64'hFFFFF);
      idle(1);
      check("t1_yw", 64'(bus.filter_fifo_data), 64'hFFFFF0);
      idle(1);
      check("t1_zw", 64'(bus.filter_fifo_data), 64'h000000);
      check("t1_zwr", 64'(bus.wr_en), 64'd1);
      idle(1);
      check("t1_end", 64'(bus.wr_en), 64'd0);
      idle(1);

      // saturation / wrap on Z
      step(1, 0, 1, 1, 2, (longint'(1) << 34) - 1, 3);
      idle(2);
      check("t2_zw", 64'(bus.filter_fifo_data), 64'(sat_z));
      idle(2);

      // near full
      step(1, 0, 1, 32768, 49152, -32768, 14);
      check("t3_wr", 64'(bus.wr_en), 64'd0);
      check("t3_ovr", 64'(bus.fifo_ovr), 64'd1);
      check("t3_vld", 64'(bus.xdata_valid), 64'd1);
      check("t3_x", 64'(bus.xdata), 64'd2);
      idle(1);

      // back-to-back
      step(1, 0, 1, 7 * 16384, 8 * 16384, 9 * 16384, 0);
      idle(1);
      step(1, 0, 1, 100000, 200000, 300000, 0);
      check("t4_ovr", 64'(bus.fifo_ovr), 64'd1);
      check("t4_x", 64'(bus.xdata), 64'd7);
      idle(3);

      // reset mid-burst
      step(1, 0, 1, 16384, 16384, 16384, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t5_wr", 64'(bus.wr_en), 64'd0);
      check("t5_busy", 64'(bus.busy), 64'd0);
      step(1, 0, 1, 3 * 16384, 16384, 2 * 16384, 0);
      check("t5_xw", 64'(bus.filter_fifo_data), 64'h000031);
      idle(4);

      // standby
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, 16384, 16384, 16384, 0);
         check("t6_wr", 64'(bus.wr_en), 64'd0);
         check("t6_vld", 64'(bus.xdata_valid), 64'd0);
         check("t6_ovr", 64'(bus.fifo_ovr), 64'd0);
      end
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) != 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0,
              rnd_val(), rnd_val(), rnd_val(),
              int'($urandom_range(0, 16)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
